// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register: the operation-select
// encoding used by the interface, the register and its testbench.
package shift_register_pkg;

  // Operation select; all four encodings are legal.
  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_CLR  = 2'b11
  } mode_t;

endpackage : shift_register_pkg

// File: rtl/shift_register_if.sv
// Control, data and serial-cascade signals of one shift register instance.
// The master drives operations in; the slave (the register) drives contents out.
interface shift_register_if #(
  parameter int N = 5
);
  import shift_register_pkg::*;

  logic         enable;
  logic         right_in;
  logic         left_in;
  logic [N-1:0] loadin;
  mode_t        working_mode;
  logic [N-1:0] data;
  logic         right_out;
  logic         left_out;

  modport master (
    output enable,
    output right_in,
    output left_in,
    output loadin,
    output working_mode,
    input  data,
    input  right_out,
    input  left_out
  );

  modport slave (
    input  enable,
    input  right_in,
    input  left_in,
    input  loadin,
    input  working_mode,
    output data,
    output right_out,
    output left_out
  );

endinterface : shift_register_if

// File: rtl/shift_register.sv
// N-bit universal shift register: parallel load, shift right/left with serial
// fill at both ends, synchronous clear, clock enable and asynchronous reset.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int N = 5
) (
  input  logic              clk,
  input  logic              rst,
  shift_register_if.slave   bus
);

  logic [N-1:0] data_q;

  // The contents are the only state; each serial input is consumed only by
  // its own shift direction, and bits shifted past either end are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (bus.enable) begin
      case (bus.working_mode)
        MODE_LOAD: data_q <= bus.loadin;
        MODE_SHR:  data_q <= {bus.left_in, data_q[N-1:1]};
        MODE_SHL:  data_q <= {data_q[N-2:0], bus.right_in};
        MODE_CLR:  data_q <= '0;
        default:   data_q <= data_q;
      endcase
    end
  end

  // Serial outputs expose the bit that the next shift in that direction loses.
  assign bus.data      = data_q;
  assign bus.right_out = data_q[0];
  assign bus.left_out  = data_q[N-1];

endmodule : shift_register

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register (N=5): reset, load, both
// shift directions, clear, enable hold and an asynchronous reset mid-stream.
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int N = 5;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  shift_register_if #(.N(N)) bus ();

  shift_register #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.enable = 1'b1;
    bus.working_mode = MODE_LOAD;
    bus.loadin = 5'b10110;
    tick();
    tests_run++;
    if (bus.data !== 5'b10110) begin
      $display("[TB] FAIL reset_preload: got %b expected %b", bus.data, 5'b10110);
      tests_failed++;
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.data !== 5'b00000 || bus.right_out !== 1'b0 || bus.left_out !== 1'b0) begin
      $display("[TB] FAIL reset_async: got data=%b ro=%b lo=%b expected 00000/0/0",
               bus.data, bus.right_out, bus.left_out);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (bus.data !== 5'b00000) begin
      $display("[TB] FAIL reset_held: got %b expected %b", bus.data, 5'b00000);
      tests_failed++;
    end
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.loadin = 5'b11111;
    bus.left_in = 1'b1;
    bus.right_in = 1'b1;
    for (int m = 0; m < 4; m++) begin
      bus.working_mode = mode_t'(m);
      tick();
      tests_run++;
      if (bus.data !== 5'b00000) begin
        $display("[TB] FAIL reset_disabled_mode%0d: got %b expected %b", m, bus.data, 5'b00000);
        tests_failed++;
      end
    end
  endtask

  task automatic test_load();
    bus.enable = 1'b1;
    bus.working_mode = MODE_LOAD;
    bus.loadin = 5'b10011;
    tick();
    tests_run++;
    if (bus.data !== 5'b10011 || bus.right_out !== 1'b1 || bus.left_out !== 1'b1) begin
      $display("[TB] FAIL load: got data=%b ro=%b lo=%b expected 10011/1/1",
               bus.data, bus.right_out, bus.left_out);
      tests_failed++;
    end
  endtask

  task automatic test_shift_right();
    bus.working_mode = MODE_SHR;
    bus.left_in = 1'b1;
    bus.right_in = 1'b0;
    bus.loadin = 5'b00000;
    tick();
    tests_run++;
    if (bus.data !== 5'b11001) begin
      $display("[TB] FAIL shr_1: got %b expected %b", bus.data, 5'b11001);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (bus.data !== 5'b11100 || bus.right_out !== 1'b0 || bus.left_out !== 1'b1) begin
      $display("[TB] FAIL shr_2: got data=%b ro=%b lo=%b expected 11100/0/1",
               bus.data, bus.right_out, bus.left_out);
      tests_failed++;
    end
  endtask

  task automatic test_shift_left();
    bus.working_mode = MODE_SHL;
    bus.right_in = 1'b0;
    bus.left_in = 1'b1;
    tick();
    tests_run++;
    if (bus.data !== 5'b11000) begin
      $display("[TB] FAIL shl_in0: got %b expected %b", bus.data, 5'b11000);
      tests_failed++;
    end
    bus.right_in = 1'b1;
    bus.left_in = 1'b0;
    tick();
    tests_run++;
    if (bus.data !== 5'b10001) begin
      $display("[TB] FAIL shl_in1: got %b expected %b", bus.data, 5'b10001);
      tests_failed++;
    end
  endtask

  task automatic test_clear_hold();
    bus.working_mode = MODE_CLR;
    bus.loadin = 5'b11111;
    tick();
    tests_run++;
    if (bus.data !== 5'b00000) begin
      $display("[TB] FAIL clear: got %b expected %b", bus.data, 5'b00000);
      tests_failed++;
    end
    bus.working_mode = MODE_LOAD;
    bus.loadin = 5'b10101;
    tick();
    tests_run++;
    if (bus.data !== 5'b10101) begin
      $display("[TB] FAIL reload: got %b expected %b", bus.data, 5'b10101);
      tests_failed++;
    end
    bus.enable = 1'b0;
    bus.loadin = 5'b01010;
    for (int m = 0; m < 4; m++) begin
      bus.working_mode = mode_t'(m);
      bus.left_in = m[0];
      bus.right_in = ~m[0];
      tick();
      tests_run++;
      if (bus.data !== 5'b10101) begin
        $display("[TB] FAIL hold_mode%0d: got %b expected %b", m, bus.data, 5'b10101);
        tests_failed++;
      end
    end
  endtask

  task automatic test_async_reset();
    bus.enable = 1'b1;
    bus.working_mode = MODE_SHR;
    bus.left_in = 1'b0;
    tick();
    tests_run++;
    if (bus.data !== 5'b01010) begin
      $display("[TB] FAIL stream_shr: got %b expected %b", bus.data, 5'b01010);
      tests_failed++;
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.data !== 5'b00000) begin
      $display("[TB] FAIL stream_rst_pulse: got %b expected %b", bus.data, 5'b00000);
      tests_failed++;
    end
    #1 rst = 1'b0;
    bus.left_in = 1'b1;
    tick();
    tests_run++;
    if (bus.data !== 5'b10000 || bus.left_out !== 1'b1) begin
      $display("[TB] FAIL stream_after_rst: got data=%b lo=%b expected 10000/1",
               bus.data, bus.left_out);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.right_in = 1'b0;
    bus.left_in = 1'b0;
    bus.loadin = '0;
    bus.working_mode = MODE_LOAD;
    repeat (2) @(negedge clk);

    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_clear_hold();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_shift_register
